imm_ext_pipe: RTL
=================

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width; SHALL be >= 2.
REQ-002 Parameter OUT_W, default 32, extended output width; SHALL satisfy OUT_W >= IN_W + 2 (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  producer presents an immediate.
REQ-007 in_ready  output  1  block can accept an immediate this cycle.
REQ-008 in_imm  input  IN_W  raw immediate.
REQ-009 in_mode  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
REQ-010 out_valid  output  1  out_imm holds a valid result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out_imm  output  OUT_W  extended result.
REQ-013 out_neg  output  1  out_imm[OUT_W-1] of the head entry.
REQ-014 out_zero  output  1  head entry out_imm equals zero.
REQ-015 count  output  2  buffer occupancy, 0..2.

Function
REQ-016 Extension SHALL be computed combinationally on input and stored already extended in a 2-entry in-order FIFO.
REQ-017 Mode 00: low IN_W bits = in_imm; upper OUT_W-IN_W bits = in_imm[IN_W-1].
REQ-018 Mode 01: low IN_W bits = in_imm; upper bits = 0.
REQ-019 Mode 10: out[OUT_W-1:OUT_W-IN_W] = in_imm; remaining low bits = 0.
REQ-020 Mode 11: sign-extend to OUT_W per mode 00, then shift left 2 within OUT_W (top 2 bits discarded, bits [1:0] = 0).
REQ-021 Push SHALL occur on a rising edge with in_valid && in_ready; pop on a rising edge with out_valid && out_ready.
REQ-022 Latency: an immediate pushed at edge N into an empty buffer SHALL appear on out_imm with out_valid=1 after edge N; no combinational in->out path.
REQ-023 in_ready SHALL equal (count != 2) and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-024 out_valid SHALL equal (count != 0); out_imm/out_neg/out_zero SHALL reflect the head entry and hold stable while out_valid && !out_ready.
REQ-025 Simultaneous push and pop at count 1: count stays 1, popped entry is the old head, new entry becomes head.
REQ-026 Pop at count 2 with no push: count 1, second entry becomes head.
REQ-027 in_valid while count 2: no push, input ignored, no state change.
REQ-028 out_ready while count 0: no effect.
REQ-029 flush SHALL have priority over push and pop: count becomes 0 at the edge; any same-cycle input is dropped and no pop is counted.
REQ-030 When out_valid=0, out_imm, out_neg and out_zero SHALL be 0.
REQ-031 Storage SHALL be a 2-slot circular buffer with 1-bit read/write pointers wrapping 1->0.

Reset
REQ-032 rst_n low SHALL immediately, without a clock edge, force count=0, out_valid=0, out_imm=0, out_neg=0, out_zero=0, pointers=0, in_ready=1.
REQ-033 Reset asserted mid-transfer SHALL discard all entries; after deassertion the first push behaves as in an empty buffer.
REQ-034 Deassertion SHALL take effect at the first rising clk edge after rst_n goes high.

Verification
REQ-035 Defaults, out_ready=1: push 0x8001 in modes 00/01/10/11 on consecutive cycles -> outputs 0xFFFF8001, 0x00008001, 0x80010000, 0xFFFE0004, each one cycle after its push; out_neg 1,0,1,1.
REQ-036 Mode 11, in_imm=0xFFFF -> out_imm 0xFFFFFFFC; mode 00, in_imm=0x0000 -> out_imm 0, out_zero=1.
REQ-037 Backpressure: out_ready=0, push 0x0001, 0x0002, 0x0003 -> count=2, in_ready=0 after second push, 0x0003 dropped; then out_ready=1 -> 0x00000001 then 0x00000002, count returns to 0.
REQ-038 count=1, push 0x0005 with out_ready=1 same cycle -> count stays 1, next output 0x00000005, order preserved.
REQ-039 count=2, flush=1 with in_valid=1 same cycle -> count=0, out_valid=0, input dropped.
REQ-040 count=2, rst_n pulsed low between clock edges -> out_valid=0, count=0 immediately; after release, push 0x7FFF mode 00 -> 0x00007FFF one cycle later.

Source files
------------

// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if: producer-side and consumer-side stream signals of imm_ext_pipe.
interface imm_ext_pipe_if #(parameter int IN_W = 16, parameter int OUT_W = 32);
    logic in_valid, in_ready, out_valid, out_ready, out_neg, out_zero;
    logic [IN_W-1:0] in_imm;
    logic [1:0] in_mode, count;
    logic [OUT_W-1:0] out_imm;
    modport slave(input in_valid, in_imm, in_mode, out_ready,
                  output in_ready, out_valid, out_imm, out_neg, out_zero, count);
    modport master(output in_valid, in_imm, in_mode, out_ready,
                   input in_ready, out_valid, out_imm, out_neg, out_zero, count);
endinterface

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: extends immediates on entry and buffers them in a 2-slot in-order FIFO.
module imm_ext_pipe #(parameter int IN_W = 16, parameter int OUT_W = 32) (
    input logic clk,
    input logic rst_n,
    input logic flush,
    imm_ext_pipe_if.slave bus
);
    localparam int PAD = OUT_W - IN_W;
    if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_widths
        $error("imm_ext_pipe: IN_W must be >= 2 and OUT_W >= IN_W + 2");
    end
    logic [OUT_W-1:0] sext, ext;
    logic [OUT_W-1:0] mem_q [2];
    logic [OUT_W-1:0] mem_d [2];
    logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, push, pop;
    logic [1:0] count_q, count_d;
    always_comb begin
        sext = {{PAD{bus.in_imm[IN_W-1]}}, bus.in_imm};
        ext = bus.in_mode == 2'd0 ? sext :
              bus.in_mode == 2'd1 ? {{PAD{1'b0}}, bus.in_imm} :
              bus.in_mode == 2'd2 ? {bus.in_imm, {PAD{1'b0}}} :
                                    {sext[OUT_W-3:0], 2'b00};
        // flush wins over both sides of the handshake
        push = !flush && bus.in_valid && count_q != 2'd2;
        pop = !flush && bus.out_ready && count_q != 2'd0;
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = ext;
        wr_ptr_d = flush ? 1'b0 : wr_ptr_q ^ push;
        rd_ptr_d = flush ? 1'b0 : rd_ptr_q ^ pop;
        count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    assign bus.count = count_q;
    assign bus.in_ready = count_q != 2'd2;
    assign bus.out_valid = count_q != 2'd0;
    assign bus.out_imm = bus.out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.out_neg = bus.out_imm[OUT_W-1];
    assign bus.out_zero = bus.out_valid && bus.out_imm == '0;
endmodule
